// File: rtl/global_pkg.sv
// Shared definitions for the microcontroller: ALU opcodes and instruction classes.
package global_pkg;

    // ALU operation codes. Encoding is fixed because DECODE forwards INS[4:0] directly.
    typedef enum logic [4:0] {
        nop          = 5'd0,
        op_lda       = 5'd1,
        op_ldb       = 5'd2,
        op_ldacc     = 5'd3,
        op_ldid      = 5'd4,
        op_mvacc2id  = 5'd5,
        op_mvacc2a   = 5'd6,
        op_mvacc2b   = 5'd7,
        op_add       = 5'd8,
        op_sub       = 5'd9,
        op_shiftl    = 5'd10,
        op_shiftr    = 5'd11,
        op_and       = 5'd12,
        op_or        = 5'd13,
        op_xor       = 5'd14,
        op_cmpe      = 5'd15,
        op_cmpg      = 5'd16,
        op_cmpl      = 5'd17,
        op_ascii2bin = 5'd18,
        op_bin2ascii = 5'd19,
        op_oeacc     = 5'd20
    } alu_op;

    // Highest defined opcode; anything above it decodes to nop.
    localparam logic [4:0] ALU_OP_MAX = 5'd20;

    // Instruction class held in INS[11:10].
    localparam logic [1:0] INS_ALU  = 2'b00;
    localparam logic [1:0] INS_JUMP = 2'b01;
    localparam logic [1:0] INS_LDWR = 2'b10;
    localparam logic [1:0] INS_SEND = 2'b11;

    // Load destination selected by INS[1:0].
    function automatic alu_op load_dest(input logic [1:0] sel);
        case (sel)
            2'd0:    return op_lda;
            2'd1:    return op_ldb;
            2'd2:    return op_ldacc;
            default: return op_ldid;
        endcase
    endfunction

endpackage

// File: rtl/cpu.sv
// Control unit: fetches 12-bit instructions, decodes them, drives the ALU,
// RAM strobes and the shared data bus, and hands the bus to the DMA on request.
module cpu
    import global_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [11:0] ROM_Data,
    input  logic        DMA_Req,
    input  logic        DMA_Ready,
    input  logic        FlagZ,
    input  logic        FlagC,
    input  logic        FlagN,
    input  logic        FlagE,
    output alu_op       ALU_op,
    output logic [11:0] ROM_Addr,
    output logic [7:0]  Databus,
    output logic [7:0]  RAM_Addr,
    output logic        RAM_Cs,
    output logic        RAM_Wen,
    output logic        RAM_Oen,
    output logic        DMA_Ack,
    output logic        DMA_Tx_Start
);

    // DMA handshake: DMA_Req is sampled only in IDLE, so an instruction is never
    // interrupted. DMA_Ack stays high while DMA_Req is held and drops the cycle
    // after DMA_Req falls. SEND pulses DMA_Tx_Start once and then waits for DMA_Ready.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        OP_FETCH  = 3'd3,
        EXECUTE   = 3'd4,
        WAIT_TX   = 3'd5,
        DMA_GRANT = 3'd6
    } state_t;

    state_t      state, state_n;
    logic [11:0] pc;
    logic [11:0] ins;
    logic [11:0] op;
    logic        bus_en;
    logic [1:0]  ins_type;

    assign ins_type = ins[11:10];
    assign ROM_Addr = pc;
    assign Databus  = bus_en ? op[7:0] : 8'hzz;

    // Flags other than Z and some instruction/operand bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{FlagC, FlagN, FlagE, ins[8:7], ins[5]};

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_n;
    end

    // Program counter and instruction/operand registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc  <= 12'h000;
            ins <= 12'h000;
            op  <= 12'h000;
        end else begin
            case (state)
                FETCH: begin
                    ins <= ROM_Data;
                    pc  <= pc + 12'd1;
                end
                OP_FETCH: begin
                    op <= ROM_Data;
                    pc <= pc + 12'd1;
                end
                EXECUTE: begin
                    if (ins_type == INS_JUMP && (!ins[0] || FlagZ))
                        pc <= op;
                end
                default: ;
            endcase
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_n      = state;
        ALU_op       = nop;
        RAM_Addr     = 8'h00;
        RAM_Cs       = 1'b0;
        RAM_Wen      = 1'b0;
        RAM_Oen      = 1'b0;
        DMA_Ack      = 1'b0;
        DMA_Tx_Start = 1'b0;
        bus_en       = 1'b0;
        case (state)
            IDLE:     state_n = DMA_Req ? DMA_GRANT : FETCH;
            FETCH:    state_n = DECODE;
            DECODE: begin
                case (ins_type)
                    INS_ALU: begin
                        if (ins[4:0] <= ALU_OP_MAX) ALU_op = alu_op'(ins[4:0]);
                        state_n = IDLE;
                    end
                    INS_SEND: begin
                        DMA_Tx_Start = 1'b1;
                        state_n      = WAIT_TX;
                    end
                    default:  state_n = OP_FETCH;
                endcase
            end
            OP_FETCH: state_n = EXECUTE;
            EXECUTE: begin
                if (ins_type == INS_LDWR) begin
                    if (!ins[9]) begin
                        ALU_op = load_dest(ins[1:0]);
                        if (ins[6]) begin
                            RAM_Addr = op[7:0];
                            RAM_Cs   = 1'b1;
                            RAM_Oen  = 1'b1;
                        end else begin
                            bus_en = 1'b1;
                        end
                    end else begin
                        ALU_op   = op_oeacc;
                        RAM_Addr = op[7:0];
                        RAM_Cs   = 1'b1;
                        RAM_Wen  = 1'b1;
                    end
                end
                state_n = IDLE;
            end
            WAIT_TX:  if (DMA_Ready) state_n = IDLE;
            DMA_GRANT: begin
                DMA_Ack = 1'b1;
                if (!DMA_Req) state_n = IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the control unit: small ROM model, hand-computed expectations.
module tb_cpu;
    import global_pkg::*;

    logic        Clk;
    logic        Rst;
    logic [11:0] ROM_Data;
    logic        DMA_Req;
    logic        DMA_Ready;
    logic        FlagZ, FlagC, FlagN, FlagE;
    alu_op       ALU_op;
    logic [11:0] ROM_Addr;
    wire  [7:0]  Databus;
    logic [7:0]  RAM_Addr;
    logic        RAM_Cs, RAM_Wen, RAM_Oen;
    logic        DMA_Ack, DMA_Tx_Start;

    logic [11:0] rom [0:4095];
    int n_vec = 0;
    int n_err = 0;

    cpu dut (
        .Clk(Clk), .Rst(Rst), .ROM_Data(ROM_Data),
        .DMA_Req(DMA_Req), .DMA_Ready(DMA_Ready),
        .FlagZ(FlagZ), .FlagC(FlagC), .FlagN(FlagN), .FlagE(FlagE),
        .ALU_op(ALU_op), .ROM_Addr(ROM_Addr), .Databus(Databus),
        .RAM_Addr(RAM_Addr), .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen),
        .DMA_Ack(DMA_Ack), .DMA_Tx_Start(DMA_Tx_Start)
    );

    // Clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Asynchronous ROM model.
    assign ROM_Data = rom[ROM_Addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        ticks(2);
        Rst = 1'b0;
    endtask

    task automatic check_no_ram(input string tag);
        check_val({tag, "_cs"},  {31'd0, RAM_Cs},  32'd0);
        check_val({tag, "_wen"}, {31'd0, RAM_Wen}, 32'd0);
        check_val({tag, "_oen"}, {31'd0, RAM_Oen}, 32'd0);
    endtask

    initial begin
        Rst = 1'b1; DMA_Req = 1'b0; DMA_Ready = 1'b0;
        FlagZ = 1'b0; FlagC = 1'b0; FlagN = 1'b0; FlagE = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = 12'h000;
        do_reset();

        // Reset state, all-zero program: ALU nop every 3 cycles.
        check_val("rst_pc", {20'd0, ROM_Addr}, 32'h000);
        check_val("rst_alu", {27'd0, ALU_op}, {27'd0, nop});
        check_val("rst_ramaddr", {24'd0, RAM_Addr}, 32'h00);
        check_val("rst_ack", {31'd0, DMA_Ack}, 32'd0);
        check_val("rst_tx", {31'd0, DMA_Tx_Start}, 32'd0);
        check_no_ram("rst");
        tick();
        check_val("nop_fetch_pc", {20'd0, ROM_Addr}, 32'h000);
        tick();
        check_val("nop_dec_pc", {20'd0, ROM_Addr}, 32'h001);
        check_val("nop_dec_alu", {27'd0, ALU_op}, {27'd0, nop});
        ticks(3);
        check_val("nop_dec2_pc", {20'd0, ROM_Addr}, 32'h002);
        check_no_ram("nop");
        tick();

        // Program image.
        rom[12'h000] = 12'h400; rom[12'h001] = 12'h0A5;
        rom[12'h0A5] = 12'h401; rom[12'h0A6] = 12'h123;
        rom[12'h0A7] = 12'h401; rom[12'h0A8] = 12'h055;
        rom[12'h055] = 12'h008; rom[12'h056] = 12'h01F;
        rom[12'h057] = 12'h802; rom[12'h058] = 12'h03C;
        rom[12'h059] = 12'h840; rom[12'h05A] = 12'h077;
        rom[12'h05B] = 12'hA00; rom[12'h05C] = 12'h010;
        rom[12'h05D] = 12'hC00;
        rom[12'h05E] = 12'h400; rom[12'h05F] = 12'hFFE;
        rom[12'hFFE] = 12'h400; rom[12'hFFF] = 12'h123;
        rom[12'h123] = 12'hA00; rom[12'h124] = 12'h010;
        do_reset();

        // Unconditional jump.
        ticks(4);
        check_val("jmp_exec_pc", {20'd0, ROM_Addr}, 32'h002);
        tick();
        check_val("jmp_pc", {20'd0, ROM_Addr}, 32'h0A5);

        // Conditional jump, not taken then taken.
        FlagZ = 1'b0;
        ticks(5);
        check_val("jz_nt_pc", {20'd0, ROM_Addr}, 32'h0A7);
        FlagZ = 1'b1;
        ticks(5);
        check_val("jz_t_pc", {20'd0, ROM_Addr}, 32'h055);
        FlagZ = 1'b0;

        // ALU instruction and an undefined opcode.
        ticks(2);
        check_val("alu_add", {27'd0, ALU_op}, {27'd0, op_add});
        ticks(3);
        check_val("alu_undef", {27'd0, ALU_op}, {27'd0, nop});
        tick();

        // Load constant into ACC.
        ticks(4);
        check_val("ldc_bus", {24'd0, Databus}, 32'h3C);
        check_val("ldc_alu", {27'd0, ALU_op}, {27'd0, op_ldacc});
        check_no_ram("ldc");
        tick();

        // Load A from memory.
        ticks(4);
        check_val("ldm_addr", {24'd0, RAM_Addr}, 32'h77);
        check_val("ldm_cs", {31'd0, RAM_Cs}, 32'd1);
        check_val("ldm_oen", {31'd0, RAM_Oen}, 32'd1);
        check_val("ldm_wen", {31'd0, RAM_Wen}, 32'd0);
        check_val("ldm_alu", {27'd0, ALU_op}, {27'd0, op_lda});
        tick();

        // Write ACC to memory.
        ticks(4);
        check_val("wr_addr", {24'd0, RAM_Addr}, 32'h10);
        check_val("wr_cs", {31'd0, RAM_Cs}, 32'd1);
        check_val("wr_wen", {31'd0, RAM_Wen}, 32'd1);
        check_val("wr_oen", {31'd0, RAM_Oen}, 32'd0);
        check_val("wr_alu", {27'd0, ALU_op}, {27'd0, op_oeacc});
        tick();
        check_no_ram("wr_done");

        // SEND: one Tx pulse, PC frozen until DMA_Ready.
        ticks(2);
        check_val("send_tx", {31'd0, DMA_Tx_Start}, 32'd1);
        check_val("send_pc", {20'd0, ROM_Addr}, 32'h05E);
        tick();
        check_val("send_tx_drop", {31'd0, DMA_Tx_Start}, 32'd0);
        ticks(4);
        check_val("send_hold_pc", {20'd0, ROM_Addr}, 32'h05E);
        DMA_Ready = 1'b1;
        tick();
        DMA_Ready = 1'b0;

        // DMA grant from IDLE.
        DMA_Req = 1'b1;
        tick();
        check_val("dma_ack", {31'd0, DMA_Ack}, 32'd1);
        tick();
        check_val("dma_ack_hold", {31'd0, DMA_Ack}, 32'd1);
        check_val("dma_pc_hold", {20'd0, ROM_Addr}, 32'h05E);
        check_no_ram("dma");
        DMA_Req = 1'b0;
        tick();
        check_val("dma_ack_drop", {31'd0, DMA_Ack}, 32'd0);

        // PC wrap through 12'hFFF.
        ticks(5);
        check_val("wrap_pre_pc", {20'd0, ROM_Addr}, 32'hFFE);
        ticks(2);
        check_val("wrap_fff_pc", {20'd0, ROM_Addr}, 32'hFFF);
        ticks(2);
        check_val("wrap_000_pc", {20'd0, ROM_Addr}, 32'h000);
        tick();
        check_val("wrap_jmp_pc", {20'd0, ROM_Addr}, 32'h123);

        // Reset asserted mid-write aborts the access immediately.
        ticks(4);
        check_val("abort_pre_wen", {31'd0, RAM_Wen}, 32'd1);
        Rst = 1'b1;
        #1;
        check_val("abort_wen", {31'd0, RAM_Wen}, 32'd0);
        check_val("abort_cs", {31'd0, RAM_Cs}, 32'd0);
        check_val("abort_pc", {20'd0, ROM_Addr}, 32'h000);
        check_val("abort_alu", {27'd0, ALU_op}, {27'd0, nop});
        tick();
        Rst = 1'b0;
        ticks(2);
        check_val("restart_pc", {20'd0, ROM_Addr}, 32'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
